axi_lite_wr_arbiter: RTL

//  Round-robin write scheduler sharing one AXI4-Lite master write path (AW/W/B) between NUM_REQ

---
 rtl/axi_lite_wr_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_wr_arbiter.sv
// Round-robin scheduler sharing one AXI4-Lite write path (AW/W/B) between NUM_REQ requesters.
// Optional watchdog/drain behaviour is enabled with `define AXI_LITE_WR_ARB_TIMEOUT_EN.
module axi_lite_wr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int ID_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]      req_data,
    input  logic [NUM_REQ*4-1:0]       req_strb,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [1:0]                 req_resp,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id,
    output logic                       timeout_err,
    output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [31:0]                m_axi_wdata,
    output logic [3:0]                 m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("axi_lite_wr_arbiter: unsupported parameter value");
    end

    logic [1:0]            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [1:0]            resp_q, resp_d;
    logic                  busy_q, busy_d;
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
`endif

    logic                  pick_any;
    logic [ID_W-1:0]       pick_id;
    int unsigned           cand;

    // First requesting index after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        pick_any = 1'b0;
        pick_id  = '0;
        cand     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= 32'(NUM_REQ)) cand = cand - 32'(NUM_REQ);
            if (!pick_any && req_valid[ID_W'(cand)]) begin
                pick_any = 1'b1;
                pick_id  = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        ready_d   = '0;
        done_d    = '0;
        resp_d    = resp_q;
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    ptr_d            = pick_id;
                    grant_d          = pick_id;
                    awaddr_d         = req_addr[pick_id*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d          = req_data[pick_id*32 +: 32];
                    wstrb_d          = req_strb[pick_id*4 +: 4];
                    awvalid_d        = 1'b1;
                    wvalid_d         = 1'b1;
                    ready_d[pick_id] = 1'b1;
                    state_d          = S_ADDR;
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
                    cnt_d            = '0;
`endif
                end
            end
            S_ADDR: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d        = 1'b0;
                    done_d[grant_q] = 1'b1;
                    resp_d          = m_axi_bresp;
                    state_d         = S_IDLE;
                end
            end
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
            S_DRAIN: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (bready_q && m_axi_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
        // A write completing on the same edge as expiry is reported normally.
        if (state_q == S_ADDR || state_q == S_RESP) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_d != S_IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                done_d[grant_q] = 1'b1;
                resp_d          = 2'b10;
                err_d           = 1'b1;
                state_d         = S_DRAIN;
            end
        end
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            grant_q   <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ready_q   <= '0;
            done_q    <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign req_ready     = ready_q;
    assign req_done      = done_q;
    assign req_resp      = resp_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
`ifdef AXI_LITE_WR_ARB_TIMEOUT_EN
    assign timeout_err   = err_q;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule
